// File: rtl/cpu_bus_pkg.sv
// Shared widths, limits and FSM encoding for the
// board-side CPU memory responder.
package cpu_bus_pkg;

  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 8;
  localparam int CNT_W       = 4;
  localparam int MAX_LATENCY = 15;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WDATA   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ACK     = 3'd3,
    ST_RELEASE = 3'd4
  } resp_state_t;

endpackage

// File: rtl/mem_array_256x8.sv
// 256x8 storage: one synchronous write port,
// one combinational read port, no reset.
module mem_array_256x8
  import cpu_bus_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [256];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_mem_responder.sv
// Target side of the CPU byte-wide memory bus:
// wait-stated reads/writes plus an IDLE-only preload port.
module cpu_mem_responder
  import cpu_bus_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_req,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_ad,
  input  logic [DATA_W-1:0] bus_ad_oe,
  output logic [DATA_W-1:0] rd_data,
  output logic              bus_ack,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              busy,
  output logic              err
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(LATENCY);

  resp_state_t       state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              we;

  logic              err_set;
  logic              lat_addr;
  logic              lat_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic [ADDR_W-1:0] mem_ra;
  logic [DATA_W-1:0] mem_rd;
  logic              we_cur;
  logic              rd_load;
  logic              oe_bad;

  assign oe_bad = (bus_ad_oe != '1);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    err_set  = 1'b0;
    lat_addr = 1'b0;
    lat_data = 1'b0;
    mem_we   = 1'b0;
    mem_wa   = addr;
    mem_wd   = wdata;
    if (ld_en && state != ST_IDLE) err_set = 1'b1;
    unique case (state)
      ST_IDLE: begin
        if (ld_en) begin
          mem_we = 1'b1;
          mem_wa = ld_addr;
          mem_wd = ld_data;
        end else if (bus_req) begin
          lat_addr = 1'b1;
          if (oe_bad) err_set = 1'b1;
          if (bus_we) begin
            state_n = ST_WDATA;
          end else if (LAT == '0) begin
            state_n = ST_ACK;
          end else begin
            state_n = ST_WAIT;
            cnt_n   = LAT;
          end
        end
      end
      ST_WDATA: begin
        if (!bus_req) begin
          state_n = ST_IDLE;
          err_set = 1'b1;
        end else begin
          lat_data = 1'b1;
          if (oe_bad) err_set = 1'b1;
          if (LAT == '0) begin
            state_n = ST_ACK;
          end else begin
            state_n = ST_WAIT;
            cnt_n   = LAT;
          end
        end
      end
      ST_WAIT: begin
        if (!bus_req) begin
          state_n = ST_IDLE;
          err_set = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
          if (cnt_n == '0) state_n = ST_ACK;
        end
      end
      ST_ACK: begin
        mem_we  = we;
        state_n = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!bus_req) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // A zero-latency read enters ACK straight from IDLE,
  // before addr/we are latched, so look at the live bus.
  assign mem_ra  = (state == ST_IDLE) ? bus_ad : addr;
  assign we_cur  = (state == ST_IDLE) ? bus_we : we;
  assign rd_load = (state_n == ST_ACK) && (state != ST_ACK) && !we_cur;

  mem_array_256x8 u_mem (
    .clk   (clk),
    .we    (mem_we && !rst),
    .waddr (mem_wa),
    .wdata (mem_wd),
    .raddr (mem_ra),
    .rdata (mem_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      addr    <= '0;
      wdata   <= '0;
      we      <= 1'b0;
      rd_data <= '0;
      bus_ack <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bus_ack <= (state_n == ST_ACK);
      busy    <= (state_n != ST_IDLE);
      err     <= err | err_set;
      if (lat_addr) begin
        addr <= bus_ad;
        we   <= bus_we;
      end
      if (lat_data) wdata <= bus_ad;
      if (rd_load) rd_data <= mem_rd;
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench: instance 0 runs LATENCY=2,
// instance 1 runs LATENCY=0; shared clock and reset.
module tb_cpu_mem_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = '0;
  logic [1:0] we  = '0;
  logic [1:0] ld  = '0;
  logic [7:0] ad  [2];
  logic [7:0] oe  [2];
  logic [7:0] la  [2];
  logic [7:0] ldd [2];
  logic [7:0] rdd [2];
  logic [1:0] ack;
  logic [1:0] busy;
  logic [1:0] err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_mem_responder #(.LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst),
    .bus_req(req[0]), .bus_we(we[0]),
    .bus_ad(ad[0]), .bus_ad_oe(oe[0]),
    .rd_data(rdd[0]), .bus_ack(ack[0]),
    .ld_en(ld[0]), .ld_addr(la[0]), .ld_data(ldd[0]),
    .busy(busy[0]), .err(err[0])
  );

  cpu_mem_responder #(.LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst),
    .bus_req(req[1]), .bus_we(we[1]),
    .bus_ad(ad[1]), .bus_ad_oe(oe[1]),
    .rd_data(rdd[1]), .bus_ack(ack[1]),
    .ld_en(ld[1]), .ld_addr(la[1]), .ld_data(ldd[1]),
    .busy(busy[1]), .err(err[1])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int d, input logic [7:0] a,
                         input logic [7:0] v);
    ld[d] = 1'b1; la[d] = a; ldd[d] = v;
    step();
    ld[d] = 1'b0;
  endtask

  task automatic do_read(input int d, input logic [7:0] a,
                         input int lat, input logic [7:0] oev,
                         input logic [7:0] exp, input string tag);
    req[d] = 1'b1; we[d] = 1'b0; ad[d] = a; oe[d] = oev;
    step();
    oe[d] = 8'hFF;
    for (int i = 0; i < lat; i++) begin
      chk({tag, "_wait_ack"}, {7'd0, ack[d]}, 8'h00);
      step();
    end
    chk({tag, "_ack"}, {7'd0, ack[d]}, 8'h01);
    chk({tag, "_data"}, rdd[d], exp);
    req[d] = 1'b0;
    step();
    step();
  endtask

  task automatic do_write(input int d, input logic [7:0] a,
                          input logic [7:0] v, input int lat,
                          input string tag);
    req[d] = 1'b1; we[d] = 1'b1; ad[d] = a; oe[d] = 8'hFF;
    step();
    ad[d] = v;
    step();
    for (int i = 0; i < lat; i++) begin
      chk({tag, "_wait_ack"}, {7'd0, ack[d]}, 8'h00);
      step();
    end
    chk({tag, "_ack"}, {7'd0, ack[d]}, 8'h01);
    req[d] = 1'b0; we[d] = 1'b0;
    step();
    step();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      ad[d] = '0; oe[d] = 8'hFF; la[d] = '0; ldd[d] = '0;
    end
    step();
    step();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ack", {7'd0, ack[d]}, 8'h00);
      chk("rst_busy", {7'd0, busy[d]}, 8'h00);
      chk("rst_err", {7'd0, err[d]}, 8'h00);
      chk("rst_rd", rdd[d], 8'h00);
    end

    // preload then read, latency 2, with busy profile
    preload(0, 8'h10, 8'hA5);
    req[0] = 1'b1; we[0] = 1'b0; ad[0] = 8'h10;
    chk("t1_c0_busy", {7'd0, busy[0]}, 8'h00);
    step();
    chk("t1_c1_busy", {7'd0, busy[0]}, 8'h01);
    chk("t1_c1_ack", {7'd0, ack[0]}, 8'h00);
    step();
    chk("t1_c2_busy", {7'd0, busy[0]}, 8'h01);
    chk("t1_c2_ack", {7'd0, ack[0]}, 8'h00);
    step();
    chk("t1_c3_ack", {7'd0, ack[0]}, 8'h01);
    chk("t1_c3_rd", rdd[0], 8'hA5);
    chk("t1_c3_busy", {7'd0, busy[0]}, 8'h01);
    req[0] = 1'b0;
    step();
    chk("t1_c4_busy", {7'd0, busy[0]}, 8'h01);
    chk("t1_c4_ack", {7'd0, ack[0]}, 8'h00);
    step();
    chk("t1_c5_busy", {7'd0, busy[0]}, 8'h00);

    // write then read back, latency 0
    do_write(1, 8'h20, 8'h3C, 0, "t2_wr");
    do_read(1, 8'h20, 0, 8'hFF, 8'h3C, "t2_rd");
    chk("t2_err", {7'd0, err[1]}, 8'h00);

    // abort during WAIT leaves memory alone
    preload(0, 8'h05, 8'h77);
    req[0] = 1'b1; we[0] = 1'b1; ad[0] = 8'h05;
    step();
    ad[0] = 8'hFF;
    step();
    req[0] = 1'b0; we[0] = 1'b0;
    step();
    chk("t3_ack", {7'd0, ack[0]}, 8'h00);
    chk("t3_err", {7'd0, err[0]}, 8'h01);
    chk("t3_busy", {7'd0, busy[0]}, 8'h00);
    step();
    chk("t3_ack2", {7'd0, ack[0]}, 8'h00);
    do_read(0, 8'h05, 2, 8'hFF, 8'h77, "t3_rd");

    // request held through ACK, latency 0
    req[1] = 1'b1; we[1] = 1'b0; ad[1] = 8'h20;
    step();
    chk("t4_ack", {7'd0, ack[1]}, 8'h01);
    chk("t4_rd", rdd[1], 8'h3C);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_hold_ack", {7'd0, ack[1]}, 8'h00);
      chk("t4_hold_busy", {7'd0, busy[1]}, 8'h01);
    end
    req[1] = 1'b0;
    step();
    chk("t4_idle_busy", {7'd0, busy[1]}, 8'h00);
    do_read(1, 8'h20, 0, 8'hFF, 8'h3C, "t4_rd2");

    // clear sticky err on instance 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_err_clr", {7'd0, err[0]}, 8'h00);

    // preload and request in the same IDLE cycle
    ld[0] = 1'b1; la[0] = 8'h30; ldd[0] = 8'h11;
    req[0] = 1'b1; we[0] = 1'b0; ad[0] = 8'h30;
    step();
    ld[0] = 1'b0;
    chk("t5_not_taken", {7'd0, busy[0]}, 8'h00);
    do_read(0, 8'h30, 2, 8'hFF, 8'h11, "t5_rd");
    chk("t5_err", {7'd0, err[0]}, 8'h00);

    // contention at address sample still completes
    do_read(0, 8'h10, 2, 8'h0F, 8'hA5, "t6_cont");
    chk("t6_err", {7'd0, err[0]}, 8'h01);

    // reset mid-WAIT
    req[0] = 1'b1; we[0] = 1'b0; ad[0] = 8'h30;
    step();
    chk("t6_wait_busy", {7'd0, busy[0]}, 8'h01);
    rst = 1'b1; req[0] = 1'b0;
    step();
    rst = 1'b0;
    chk("t6_rst_ack", {7'd0, ack[0]}, 8'h00);
    chk("t6_rst_busy", {7'd0, busy[0]}, 8'h00);
    chk("t6_rst_err", {7'd0, err[0]}, 8'h00);
    chk("t6_rst_rd", rdd[0], 8'h00);
    step();
    chk("t6_rst_noack", {7'd0, ack[0]}, 8'h00);
    do_read(0, 8'h10, 2, 8'hFF, 8'hA5, "t6_keep");
    do_read(1, 8'h20, 0, 8'hFF, 8'h3C, "t6_keep1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
# cpu_mem_responder

Board-side memory responder for the byte-wide external memory bus that `tt_um_cpu` drives over its pins. The CPU is the initiator and this block is the target. It holds a 256×8 memory, answers CPU read and write requests after a programmable number of wait states, and provides a preload port so the bench or host can load a program before the CPU runs. It sits outside the CPU in the testbench/FPGA harness:

- `uo_out[7:6]` and `uio_out`/`uio_oe` come in.
- `rd_data` and `bus_ack` go back to `uio_in` and `ui_in[7]`.

## Interface

Parameters:
- `LATENCY`, 2: wait states inserted before `bus_ack`; legal range 0..15.

Ports:
- `clk`  in  1: single clock; all logic rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `bus_req`  in  1: CPU request strobe (`uo_out[7]`).
- `bus_we`  in  1: 1 = write, 0 = read (`uo_out[6]`); sampled with the address.
- `bus_ad`  in  8: multiplexed bus (`uio_out`). Carries the address in the address phase and the write data in the data phase.
- `bus_ad_oe`  in  8: CPU output enables (`uio_oe`); must be 8'hFF whenever `bus_ad` is sampled.
- `rd_data`  out  8: read data to `uio_in`; valid in the ack cycle, held until the next read ack.
- `bus_ack`  out  1: one-cycle completion pulse to `ui_in[7]`.
- `ld_en`  in  1: preload write strobe.
- `ld_addr`  in  8: preload address.
- `ld_data`  in  8: preload data.
- `busy`  out  1: high in every state except IDLE.
- `err`  out  1: sticky protocol error flag.

## Operation

States: IDLE, WDATA, WAIT, ACK, RELEASE.

- **IDLE.** `ld_en`=1 writes `ld_data` to `mem[ld_addr]` and blocks bus acceptance that cycle. Otherwise, if `bus_req`=1:
  - Latch `bus_ad` as the address and latch `bus_we`.
  - Write: go to WDATA.
  - Read: go to WAIT with counter = `LATENCY`, or to ACK if `LATENCY`=0.
- **WDATA.** Latch `bus_ad` as write data, then go to WAIT, or to ACK if `LATENCY`=0.
- **WAIT.** Decrement the counter each cycle. When it reaches 0, go to ACK.
- **ACK.** `bus_ack`=1 for exactly this cycle.
  - Read: `rd_data` ← `mem[addr]`, registered so it is valid in this cycle.
  - Write: commit `mem[addr]` ← wdata at the end of this cycle.
  - Next state is RELEASE.
- **RELEASE.** Stay until `bus_req`=0, then go to IDLE. The CPU must therefore drop `bus_req` for at least one cycle between transactions.
- **Abort.** `bus_req`=0 while in WDATA or WAIT:
  - Go to IDLE and set `err`.
  - No write commit and no ack.
- **Contention.** `bus_ad_oe` ≠ 8'hFF on an address or data sample sets `err`. The transaction still completes.
- **Preload outside IDLE.** `ld_en` in any state other than IDLE is ignored and sets `err`.
- **Reset.**
  - State → IDLE; `bus_ack`=0, `rd_data`=8'h00, `busy`=0, `err`=0, counter=0.
  - Memory contents are NOT reset: they are retained across `rst` and undefined only at power-up.
- **Reset during a transaction.** Drops the transaction; no commit, no ack.
- **Widths.** Address is 8 bits, so there is no out-of-range case. The counter is 4 bits.

## Timing

Cycle 0 is the first cycle in which `bus_req`=1 is accepted.
- **Read:** `bus_ack` is high in cycle 1+`LATENCY`.
- **Write:** data is sampled in cycle 1 and `bus_ack` is high in cycle 2+`LATENCY`.
- **Commit visibility:** a committed write is visible to a read accepted in any later transaction.
- **Preload visibility:** a preload is visible to a read accepted in the following cycle.
- **Throughput:** at most one transaction per 3+`LATENCY` cycles (read) or 4+`LATENCY` cycles (write), including the RELEASE cycle.
- **Outputs:** all outputs are registered; there are no combinational input-to-output paths.

## Structure

- **Package `cpu_bus_pkg`:**
  - `ADDR_W`=8 and `DATA_W`=8.
  - State enum `resp_state_t`.
  - `MAX_LATENCY`=15.
- **Sub-module `mem_array_256x8`:**
  - Single write port; synchronous write.
  - Combinational read; the read result is registered in the responder.
  - Write-port mux (preload vs. bus commit) stays in the responder. The two writers are never simultaneous, because preload is accepted only in IDLE.

## Test plan

- **Preload and read, `LATENCY`=2.** Preload `mem[8'h10]`=8'hA5, then read 8'h10. Required: `bus_ack` in cycle 3 with `rd_data`=8'hA5; `busy` high in cycles 1–4.
- **Write then read back, `LATENCY`=0.** Write 8'h3C to 8'h20, then read 8'h20. Required: write ack in cycle 2, read ack in cycle 1 with `rd_data`=8'h3C; `err`=0.
- **Abort during WAIT.** Write 8'hFF to 8'h05 and drop `bus_req` in WAIT. Required: no ack, `err`=1, `mem[8'h05]` unchanged on a later read.
- **Request held through ACK.** Keep `bus_req` high for 5 cycles after ack. Required: state stays RELEASE, exactly one ack pulse, next request accepted only after `bus_req` low for one cycle.
- **Simultaneous preload and request.** Assert `ld_en` (8'h30←8'h11) and a read of 8'h30 in the same IDLE cycle. Required: preload happens, read is accepted the next cycle and returns 8'h11.
- **Contention and reset.**
  - `bus_ad_oe`=8'h0F at the address sample: required `err`=1 and the read still acks.
  - Assert `rst` mid-WAIT: required all outputs return to reset values and `mem` contents are retained.
